// File: rtl/time_set_ctrl.sv
// Button-driven hour/minute editor for the FND time clock: synchronizes and
// debounces SET/UP/DOWN, runs the edit FSM and issues a one-cycle load strobe.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_set,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [5:0] i_hour,
    input  logic [5:0] i_min,
    output logic [5:0] o_hour,
    output logic [5:0] o_min,
    output logic       o_load,
    output logic       o_editing,
    output logic [1:0] o_field
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_EDIT_HOUR = 2'b01,
        ST_EDIT_MIN  = 2'b10
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {i_btn_down, i_btn_up, i_btn_set};

    // Per button: 2-flop synchronizer, then a counter that must see the new
    // level for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic          s1_q, s2_q, stable_q, press_q;
        logic [CW-1:0] cnt_q;

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                press_q  <= 1'b0;
                cnt_q    <= '0;
            end else begin
                s1_q    <= btn_raw[gi];
                s2_q    <= s1_q;
                press_q <= 1'b0;
                if (s2_q == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q    <= '0;
                    stable_q <= s2_q;
                    press_q  <= s2_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end

        assign press[gi] = press_q;
    end

    state_t        state_q, state_d;
    logic [5:0]    hour_q, hour_d, min_q, min_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          load_q, load_d;
    logic          editing_q, editing_d;
    logic [1:0]    field_q, field_d;
    logic          p_set, step_up, step_dn;

    // Set dominates; up and down together cancel each other.
    assign p_set   = press[0];
    assign step_up = press[1] & ~press[2] & ~p_set;
    assign step_dn = press[2] & ~press[1] & ~p_set;

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        tmo_d   = tmo_q;
        load_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (p_set) begin
                    hour_d  = (i_hour > 6'd23) ? 6'd0 : i_hour;
                    min_d   = (i_min > 6'd59) ? 6'd0 : i_min;
                    state_d = ST_EDIT_HOUR;
                end
            end
            ST_EDIT_HOUR: begin
                tmo_d = '0;
                if (p_set) begin
                    state_d = ST_EDIT_MIN;
                end else if (step_up) begin
                    hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                end else if (step_dn) begin
                    hour_d = (hour_q == 6'd0) ? 6'd23 : hour_q - 6'd1;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_EDIT_MIN: begin
                tmo_d = '0;
                if (p_set) begin
                    state_d = ST_IDLE;
                    load_d  = 1'b1;
                end else if (step_up) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end else if (step_dn) begin
                    min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        editing_d = (state_d != ST_IDLE);
        field_d   = state_d;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            hour_q    <= '0;
            min_q     <= '0;
            tmo_q     <= '0;
            load_q    <= 1'b0;
            editing_q <= 1'b0;
            field_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            tmo_q     <= tmo_d;
            load_q    <= load_d;
            editing_q <= editing_d;
            field_q   <= field_d;
        end
    end

    assign o_hour    = hour_q;
    assign o_min     = min_q;
    assign o_load    = load_q;
    assign o_editing = editing_q;
    assign o_field   = field_q;

endmodule
